// File: rtl/rs_issue_scheduler.sv
// Reservation-station slot scheduler: lowest-free-slot allocation plus
// oldest-ready-first issue selection tracked by a pairwise age matrix.
module rs_issue_scheduler #(
    parameter int NUM_RS = 4,
    parameter int CNT_W  = $clog2(NUM_RS + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              needToRestore_i,
    input  logic              alloc_req_i,
    output logic [NUM_RS-1:0] alloc_gnt_o,
    output logic              full_o,
    input  logic [NUM_RS-1:0] rs_ready_i,
    input  logic              stall_i,
    output logic [NUM_RS-1:0] issue_gnt_o,
    output logic              issue_valid_o,
    output logic              issue_fire_o,
    output logic [CNT_W-1:0]  occupancy_o
);

    logic [NUM_RS-1:0]             r_valid;
    logic [NUM_RS-1:0][NUM_RS-1:0] r_older;
    logic [CNT_W-1:0]              r_occ;

    logic                          w_block;
    logic                          w_found;
    logic [NUM_RS-1:0]             w_alloc_gnt;
    logic [NUM_RS-1:0]             w_cand;
    logic [NUM_RS-1:0]             w_issue_gnt;
    logic                          w_alloc_any;
    logic                          w_fire;
    logic [NUM_RS-1:0]             w_valid_next;
    logic [NUM_RS-1:0][NUM_RS-1:0] w_older_next;

    assign w_block = reset_i | needToRestore_i;
    assign w_cand  = r_valid & rs_ready_i;

    // Lowest-index free slot; a slot freed this cycle is still marked valid,
    // so it only becomes grantable once the issue has been registered.
    always_comb begin
        w_alloc_gnt = '0;
        w_found     = 1'b0;
        if (alloc_req_i && !w_block) begin
            for (int k = 0; k < NUM_RS; k++) begin
                if (!w_found && !r_valid[k]) begin
                    w_alloc_gnt[k] = 1'b1;
                    w_found        = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_issue_gnt = '0;
        if (!w_block) begin
            for (int k = 0; k < NUM_RS; k++) begin
                w_issue_gnt[k] = w_cand[k];
                for (int i = 0; i < NUM_RS; i++) begin
                    if (i != k && w_cand[i] && r_older[i][k]) begin
                        w_issue_gnt[k] = 1'b0;
                    end
                end
            end
        end
    end

    assign w_alloc_any = |w_alloc_gnt;
    assign w_fire      = (|w_issue_gnt) & ~stall_i;

    // Issue clearing is applied after allocation so a slot leaving this cycle
    // never ends up recorded as older than the newcomer.
    always_comb begin
        w_valid_next = r_valid;
        w_older_next = r_older;
        for (int k = 0; k < NUM_RS; k++) begin
            if (w_alloc_gnt[k]) begin
                w_valid_next[k] = 1'b1;
                for (int i = 0; i < NUM_RS; i++) begin
                    w_older_next[i][k] = (i != k) && r_valid[i];
                    w_older_next[k][i] = 1'b0;
                end
            end
        end
        if (w_fire) begin
            for (int k = 0; k < NUM_RS; k++) begin
                if (w_issue_gnt[k]) begin
                    w_valid_next[k] = 1'b0;
                    for (int i = 0; i < NUM_RS; i++) begin
                        w_older_next[i][k] = 1'b0;
                        w_older_next[k][i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || needToRestore_i) begin
            r_valid <= '0;
            r_older <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_older <= w_older_next;
            if (w_alloc_any && !w_fire) begin
                r_occ <= r_occ + CNT_W'(1);
            end else if (w_fire && !w_alloc_any) begin
                r_occ <= r_occ - CNT_W'(1);
            end
        end
    end

    // The occupancy counter must never be asked to step past its range.
    always_ff @(posedge clk_i) begin
        if (!w_block) begin
            assert (!(w_alloc_any && !w_fire && r_occ == CNT_W'(NUM_RS)));
            assert (!(w_fire && !w_alloc_any && r_occ == '0));
            assert ($onehot0(w_issue_gnt));
        end
    end

    assign alloc_gnt_o   = w_alloc_gnt;
    assign full_o        = &r_valid;
    assign issue_gnt_o   = w_issue_gnt;
    assign issue_valid_o = |w_issue_gnt;
    assign issue_fire_o  = w_fire;
    assign occupancy_o   = r_occ;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed testbench for rs_issue_scheduler with NUM_RS=4; inputs change
// 1ns after posedge and outputs are sampled 3ns later.
module tb_rs_issue_scheduler;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       needToRestore_i = 1'b0;
    logic       alloc_req_i = 1'b0;
    logic [3:0] alloc_gnt_o;
    logic       full_o;
    logic [3:0] rs_ready_i = 4'b0000;
    logic       stall_i = 1'b0;
    logic [3:0] issue_gnt_o;
    logic       issue_valid_o;
    logic       issue_fire_o;
    logic [2:0] occupancy_o;

    int nChecks = 0;
    int nFails  = 0;

    rs_issue_scheduler #(.NUM_RS(4)) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .needToRestore_i(needToRestore_i),
        .alloc_req_i(alloc_req_i),
        .alloc_gnt_o(alloc_gnt_o),
        .full_o(full_o),
        .rs_ready_i(rs_ready_i),
        .stall_i(stall_i),
        .issue_gnt_o(issue_gnt_o),
        .issue_valid_o(issue_valid_o),
        .issue_fire_o(issue_fire_o),
        .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        reset_i = 1'b1; needToRestore_i = 1'b0; alloc_req_i = 1'b0;
        rs_ready_i = 4'b0000; stall_i = 1'b0;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic allocN(input int n);
        rs_ready_i = 4'b0000;
        alloc_req_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
        alloc_req_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; alloc_req_i = 1'b1; rs_ready_i = 4'b1111;
        tick();
        #3;
        nChecks++; if (alloc_gnt_o !== 4'b0000) begin nFails++; $display("[TB] FAIL rst_alloc_gnt: got %b want 0000", alloc_gnt_o); end
        nChecks++; if (issue_gnt_o !== 4'b0000 || issue_valid_o !== 1'b0 || issue_fire_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_issue: got gnt=%b v=%b f=%b want 0000/0/0", issue_gnt_o, issue_valid_o, issue_fire_o); end
        tick();
        reset_i = 1'b0; alloc_req_i = 1'b0; rs_ready_i = 4'b0000;
        #3;
        nChecks++; if (occupancy_o !== 3'd0 || full_o !== 1'b0) begin nFails++; $display("[TB] FAIL post_rst_state: got occ=%0d full=%b want 0/0", occupancy_o, full_o); end
        nChecks++; if (alloc_gnt_o !== 4'b0000 || issue_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL post_rst_grants: got alloc=%b iv=%b want 0000/0", alloc_gnt_o, issue_valid_o); end
    endtask

    task automatic test_fill();
        logic [3:0] expGnt;
        doReset();
        alloc_req_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            expGnt = 4'b0001 << n;
            #3;
            nChecks++; if (alloc_gnt_o !== expGnt) begin nFails++; $display("[TB] FAIL fill_gnt%0d: got %b want %b", n, alloc_gnt_o, expGnt); end
            tick();
        end
        #3;
        nChecks++; if (full_o !== 1'b1 || occupancy_o !== 3'd4) begin nFails++; $display("[TB] FAIL fill_full: got full=%b occ=%0d want 1/4", full_o, occupancy_o); end
        nChecks++; if (alloc_gnt_o !== 4'b0000) begin nFails++; $display("[TB] FAIL fill_fifth: got %b want 0000", alloc_gnt_o); end
        alloc_req_i = 1'b0;
    endtask

    task automatic test_age_order();
        logic [3:0] expIss [3] = '{4'b0100, 4'b0001, 4'b1000};
        doReset();
        allocN(3);
        rs_ready_i = 4'b0011;
        tick();
        tick();
        allocN(3);
        rs_ready_i = 4'b1101;
        for (int n = 0; n < 3; n++) begin
            #3;
            nChecks++; if (issue_gnt_o !== expIss[n] || issue_fire_o !== 1'b1) begin nFails++; $display("[TB] FAIL age_issue%0d: got gnt=%b f=%b want %b/1", n, issue_gnt_o, issue_fire_o, expIss[n]); end
            tick();
        end
        #3;
        nChecks++; if (issue_valid_o !== 1'b0 || occupancy_o !== 3'd1) begin nFails++; $display("[TB] FAIL age_rest: got iv=%b occ=%0d want 0/1", issue_valid_o, occupancy_o); end
        rs_ready_i = 4'b0000;
    endtask

    task automatic test_latency();
        doReset();
        alloc_req_i = 1'b1; rs_ready_i = 4'b0001;
        #3;
        nChecks++; if (alloc_gnt_o !== 4'b0001 || issue_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL lat_same: got alloc=%b iv=%b want 0001/0", alloc_gnt_o, issue_valid_o); end
        tick();
        alloc_req_i = 1'b0;
        #3;
        nChecks++; if (issue_gnt_o !== 4'b0001 || issue_fire_o !== 1'b1) begin nFails++; $display("[TB] FAIL lat_next: got gnt=%b f=%b want 0001/1", issue_gnt_o, issue_fire_o); end
        tick();
        rs_ready_i = 4'b0000;
    endtask

    task automatic test_stall();
        doReset();
        allocN(4);
        rs_ready_i = 4'b1111; stall_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #3;
            nChecks++; if (issue_gnt_o !== 4'b0001 || issue_fire_o !== 1'b0 || occupancy_o !== 3'd4) begin nFails++; $display("[TB] FAIL stall%0d: got gnt=%b f=%b occ=%0d want 0001/0/4", n, issue_gnt_o, issue_fire_o, occupancy_o); end
            tick();
        end
        stall_i = 1'b0;
        #3;
        nChecks++; if (issue_gnt_o !== 4'b0001 || issue_fire_o !== 1'b1) begin nFails++; $display("[TB] FAIL stall_release: got gnt=%b f=%b want 0001/1", issue_gnt_o, issue_fire_o); end
        tick();
        rs_ready_i = 4'b0000;
        #3;
        nChecks++; if (occupancy_o !== 3'd3) begin nFails++; $display("[TB] FAIL stall_occ: got %0d want 3", occupancy_o); end
    endtask

    task automatic test_back_to_back();
        doReset();
        allocN(4);
        rs_ready_i = 4'b0010; alloc_req_i = 1'b1;
        #3;
        nChecks++; if (alloc_gnt_o !== 4'b0000 || issue_gnt_o !== 4'b0010 || issue_fire_o !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_fire: got alloc=%b iss=%b f=%b want 0000/0010/1", alloc_gnt_o, issue_gnt_o, issue_fire_o); end
        tick();
        rs_ready_i = 4'b0000;
        #3;
        nChecks++; if (alloc_gnt_o !== 4'b0010 || occupancy_o !== 3'd3) begin nFails++; $display("[TB] FAIL b2b_realloc: got alloc=%b occ=%0d want 0010/3", alloc_gnt_o, occupancy_o); end
        tick();
        alloc_req_i = 1'b0;
        #3;
        nChecks++; if (occupancy_o !== 3'd4 || full_o !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_full: got occ=%0d full=%b want 4/1", occupancy_o, full_o); end
        // age order is now 0,2,3,1; drain slot 0, then alloc and issue together
        rs_ready_i = 4'b0001;
        tick();
        rs_ready_i = 4'b0100; alloc_req_i = 1'b1;
        #3;
        nChecks++; if (alloc_gnt_o !== 4'b0001 || issue_gnt_o !== 4'b0100 || issue_fire_o !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_both: got alloc=%b iss=%b f=%b want 0001/0100/1", alloc_gnt_o, issue_gnt_o, issue_fire_o); end
        tick();
        alloc_req_i = 1'b0; rs_ready_i = 4'b1011;
        #3;
        nChecks++; if (occupancy_o !== 3'd3 || issue_gnt_o !== 4'b1000) begin nFails++; $display("[TB] FAIL b2b_after: got occ=%0d iss=%b want 3/1000", occupancy_o, issue_gnt_o); end
        rs_ready_i = 4'b0000;
    endtask

    task automatic test_restore();
        doReset();
        allocN(3);
        #3;
        nChecks++; if (occupancy_o !== 3'd3) begin nFails++; $display("[TB] FAIL rest_pre_occ: got %0d want 3", occupancy_o); end
        alloc_req_i = 1'b1; rs_ready_i = 4'b0001; needToRestore_i = 1'b1;
        #1;
        nChecks++; if (alloc_gnt_o !== 4'b0000 || issue_gnt_o !== 4'b0000 || issue_valid_o !== 1'b0 || issue_fire_o !== 1'b0) begin nFails++; $display("[TB] FAIL rest_grants: got alloc=%b iss=%b v=%b f=%b want all 0", alloc_gnt_o, issue_gnt_o, issue_valid_o, issue_fire_o); end
        tick();
        needToRestore_i = 1'b0; alloc_req_i = 1'b0; rs_ready_i = 4'b1111;
        #3;
        nChecks++; if (occupancy_o !== 3'd0 || full_o !== 1'b0 || issue_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL rest_after: got occ=%0d full=%b iv=%b want 0/0/0", occupancy_o, full_o, issue_valid_o); end
        rs_ready_i = 4'b0000;
    endtask

    task automatic test_mid_reset();
        doReset();
        allocN(2);
        #3;
        nChecks++; if (occupancy_o !== 3'd2) begin nFails++; $display("[TB] FAIL mrst_pre: got %0d want 2", occupancy_o); end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #3;
        nChecks++; if (occupancy_o !== 3'd0) begin nFails++; $display("[TB] FAIL mrst_occ: got %0d want 0", occupancy_o); end
        alloc_req_i = 1'b1;
        #1;
        nChecks++; if (alloc_gnt_o !== 4'b0001) begin nFails++; $display("[TB] FAIL mrst_alloc: got %b want 0001", alloc_gnt_o); end
        tick();
        alloc_req_i = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_age_order();
        test_latency();
        test_stall();
        test_back_to_back();
        test_restore();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
